// File: rtl/ex_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: M-extension op
// encoding, FSM state type and small op-decode helpers.
package struct_pckg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // First operand is treated as two's complement.
  function automatic logic op_signed_a(input muldiv_op_e op);
    case (op)
      MUL, MULH, MULHSU, DIV, REM: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  // Second operand is treated as two's complement.
  function automatic logic op_signed_b(input muldiv_op_e op);
    case (op)
      MUL, MULH, DIV, REM: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One clock's worth of datapath: UNROLL chained shift-add (multiply) or
// restoring-subtract (divide) steps on the {hi, lo} accumulator pair.
// Multiply: lo holds the multiplier, opb the multiplicand; product shifts
// right into {hi, lo}. Divide: lo holds the dividend (MSB-aligned), hi the
// partial remainder, opb the divisor; quotient bits shift into lo.
module ex_muldiv_step #(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] h [0:UNROLL];
  logic [XLEN-1:0] l [0:UNROLL];

  assign h[0] = hi;
  assign l[0] = lo;

  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    assign sum     = {1'b0, h[k]} + (l[k][0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    assign shifted = {h[k], l[k][XLEN-1]};
    assign ge      = (shifted >= {1'b0, opb});
    assign diff    = shifted[XLEN-1:0] - opb;

    assign h[k+1] = is_div ? (ge ? diff : shifted[XLEN-1:0]) : sum[XLEN:1];
    assign l[k+1] = is_div ? {l[k][XLEN-2:0], ge} : {sum[0], l[k][XLEN-1:1]};
  end

  assign hi_next = h[UNROLL];
  assign lo_next = l[UNROLL];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV M-extension multiply/divide unit. Operates on operand
// magnitudes and sign-corrects the final result; divide-by-zero and signed
// overflow complete in one cycle without iterating.
module ex_muldiv
  import struct_pckg::*;
#(
  parameter int XLEN   = 64,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic            i_is_word,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_busy
);

  localparam int CNTW = $clog2(XLEN / UNROLL + 1);
  localparam int WSH  = XLEN - 32;
  localparam logic [CNTW-1:0]   N_FULL  = CNTW'(XLEN / UNROLL);
  localparam logic [CNTW-1:0]   N_WORD  = CNTW'(32 / UNROLL);
  localparam logic [CNTW-1:0]   CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ZERO_X  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONES_X  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};

  if (!((XLEN == 32 || XLEN == 64) && (UNROLL == 1 || UNROLL == 2 || UNROLL == 4))) begin : g_param_check
    $error("ex_muldiv: XLEN must be 32 or 64, UNROLL must be 1, 2 or 4");
  end

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  muldiv_state_e   state_r;
  logic            valid_r;
  logic            busy_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      rd_r;
  logic [CNTW-1:0] cnt_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] opb_r;
  muldiv_op_e      op_r;
  logic            word_r;
  logic            neg_r;

  // Request-side decode
  muldiv_op_e      op_s;
  logic            eff_word_s;
  logic            sa_s, sb_s, is_div_in_s, is_rem_in_s;
  logic [XLEN-1:0] a_val_s, b_val_s, a_mag_s, b_mag_s, a_res_s, min_val_s;
  logic            a_neg_s, b_neg_s, b_zero_s, ovf_s, special_s, accept_s;
  logic [XLEN-1:0] spec_res_s, init_lo_s, init_b_s;
  logic            neg_in_s;

  // Completion-side result formation
  logic [XLEN-1:0]   hi_nx_s, lo_nx_s;
  logic [2*XLEN-1:0] prod_raw_s, prod_fix_s;
  logic [XLEN-1:0]   q_fix_s, r_fix_s, mul_res_s, div_res_s, final_res_s;

  ex_muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div  (op_r[2]),
    .hi      (hi_r),
    .lo      (lo_r),
    .opb     (opb_r),
    .hi_next (hi_nx_s),
    .lo_next (lo_nx_s)
  );

  // Decode an incoming request: operand magnitudes, signs, special cases.
  always_comb begin
    op_s        = muldiv_op_e'(i_op);
    eff_word_s  = (XLEN == 64) ? i_is_word : 1'b0;
    sa_s        = op_signed_a(op_s);
    sb_s        = op_signed_b(op_s);
    is_div_in_s = i_op[2];
    is_rem_in_s = i_op[1];
    a_val_s     = eff_word_s ? (sa_s ? sext32(i_rs1[31:0]) : zext32(i_rs1[31:0])) : i_rs1;
    b_val_s     = eff_word_s ? (sb_s ? sext32(i_rs2[31:0]) : zext32(i_rs2[31:0])) : i_rs2;
    a_neg_s     = sa_s & a_val_s[XLEN-1];
    b_neg_s     = sb_s & b_val_s[XLEN-1];
    a_mag_s     = a_neg_s ? (~a_val_s + ONE_X) : a_val_s;
    b_mag_s     = b_neg_s ? (~b_val_s + ONE_X) : b_val_s;
    a_res_s     = eff_word_s ? sext32(i_rs1[31:0]) : i_rs1;
    min_val_s   = eff_word_s ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    b_zero_s    = (b_val_s == ZERO_X);
    ovf_s       = is_div_in_s & sa_s & (a_val_s == min_val_s) & (b_val_s == ONES_X);
    special_s   = is_div_in_s & (b_zero_s | ovf_s);
    accept_s    = i_valid & (state_r == IDLE) & ~i_flush;
    neg_in_s    = (is_div_in_s & is_rem_in_s) ? a_neg_s : (a_neg_s ^ b_neg_s);
    init_lo_s   = is_div_in_s ? (eff_word_s ? (a_mag_s << WSH) : a_mag_s) : b_mag_s;
    init_b_s    = is_div_in_s ? b_mag_s : a_mag_s;
    if (b_zero_s) begin
      spec_res_s = is_rem_in_s ? a_res_s : ONES_X;
    end else if (ovf_s) begin
      spec_res_s = is_rem_in_s ? ZERO_X : a_res_s;
    end else begin
      spec_res_s = ZERO_X;
    end
  end

  // Form the architectural result from the post-final-step accumulators.
  always_comb begin
    prod_raw_s = word_r ? ({hi_nx_s, lo_nx_s} >> WSH) : {hi_nx_s, lo_nx_s};
    prod_fix_s = neg_r ? (~prod_raw_s + ONE_2X) : prod_raw_s;
    q_fix_s    = neg_r ? (~lo_nx_s + ONE_X) : lo_nx_s;
    r_fix_s    = neg_r ? (~hi_nx_s + ONE_X) : hi_nx_s;
    if (op_r == MUL) begin
      mul_res_s = word_r ? sext32(prod_fix_s[31:0]) : prod_fix_s[XLEN-1:0];
    end else begin
      mul_res_s = word_r ? sext32(prod_fix_s[63:32]) : prod_fix_s[2*XLEN-1:XLEN];
    end
    div_res_s   = op_r[1] ? r_fix_s : q_fix_s;
    div_res_s   = word_r ? sext32(div_res_s[31:0]) : div_res_s;
    final_res_s = op_r[2] ? div_res_s : mul_res_s;
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      result_r <= ZERO_X;
      rd_r     <= 5'd0;
      cnt_r    <= {CNTW{1'b0}};
      hi_r     <= ZERO_X;
      lo_r     <= ZERO_X;
      opb_r    <= ZERO_X;
      op_r     <= MUL;
      word_r   <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r   <= op_s;
            word_r <= eff_word_s;
            neg_r  <= neg_in_s;
            rd_r   <= i_rd;
            busy_r <= 1'b1;
            if (special_s) begin
              result_r <= spec_res_s;
              valid_r  <= 1'b1;
              state_r  <= DONE;
            end else begin
              hi_r    <= ZERO_X;
              lo_r    <= init_lo_s;
              opb_r   <= init_b_s;
              cnt_r   <= eff_word_s ? N_WORD : N_FULL;
              state_r <= BUSY;
            end
          end
        end
        BUSY: begin
          if (i_flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CNTW{1'b0}};
          end else begin
            hi_r  <= hi_nx_s;
            lo_r  <= lo_nx_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              result_r <= final_res_s;
              valid_r  <= 1'b1;
              state_r  <= DONE;
            end
          end
        end
        DONE: begin
          if (i_flush || i_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = (state_r == IDLE);
  assign o_valid  = valid_r;
  assign o_busy   = busy_r;
  assign o_result = result_r;
  assign o_rd     = rd_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (XLEN=64, UNROLL=1).
module tb_ex_muldiv;
  import struct_pckg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_is_word, i_flush, o_valid, i_ready, o_busy;
  logic [2:0]  i_op;
  logic [63:0] i_rs1, i_rs2, o_result;
  logic [4:0]  i_rd, o_rd;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv #(.XLEN(64), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_is_word(i_is_word), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd(o_rd), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for o_valid, return result and edge count.
  task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       output logic [63:0] res, output logic [4:0] rd_o, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_op = op; i_is_word = w; i_rs1 = a; i_rs2 = b; i_rd = rd;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o_result;
    rd_o = o_rd;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] res, r0;
    logic [4:0]  rdo, rd0;
    int          lat, seen, bad;

    vecs[0]  = '{MUL,    1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_neg"};
    vecs[1]  = '{MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_max"};
    vecs[2]  = '{DIVU,   1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by0"};
    vecs[3]  = '{REMU,   1'b0, 64'd100, 64'd0, 64'd100, 1, "remu_by0"};
    vecs[4]  = '{DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, "div_ovf"};
    vecs[5]  = '{REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, "rem_ovf"};
    vecs[6]  = '{DIV,    1'b1, 64'h0000_0000_FFFF_FFF6, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw"};
    vecs[7]  = '{REM,    1'b1, 64'h0000_0000_FFFF_FFF6, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw"};
    vecs[8]  = '{MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulh_neg"};
    vecs[9]  = '{MULHSU, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhsu"};
    vecs[10] = '{MULHU,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h2, 65, "mulhu_small"};
    vecs[11] = '{DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_negdvd"};
    vecs[12] = '{REM,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_negdvd"};
    vecs[13] = '{DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65, "divu"};
    vecs[14] = '{REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65, "remu"};
    vecs[15] = '{REM,    1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, "rem_negdvs"};
    vecs[16] = '{MUL,    1'b1, 64'h0000_0001_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33, "mulw"};
    vecs[17] = '{DIVU,   1'b1, 64'h1234_5678_FFFF_FFFE, 64'hABCD_0000_0000_0002, 64'h0000_0000_7FFF_FFFF, 33, "divuw"};
    vecs[18] = '{DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf"};
    vecs[19] = '{REMU,   1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, "remuw_by0"};

    rst = 1'b1; i_valid = 1'b0; i_op = 3'd0; i_is_word = 1'b0; i_rs1 = 64'h0;
    i_rs2 = 64'h0; i_rd = 5'd0; i_flush = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid",  64'(o_valid),  64'h0);
    check("reset_ready",  64'(o_ready),  64'h1);
    check("reset_busy",   64'(o_busy),   64'h0);
    check("reset_result", o_result,      64'h0);
    check("reset_rd",     64'(o_rd),     64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i + 1), res, rdo, lat);
      check({vecs[i].name, "_result"},  res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_rd"},      64'(rdo), 64'(i + 1));
    end

    // Flush 10 cycles into BUSY: IDLE next edge, no result ever
    @(negedge clk);
    i_valid = 1'b1; i_op = DIVU; i_is_word = 1'b0; i_rs1 = 64'd100; i_rs2 = 64'd7; i_rd = 5'd9;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush_pre_busy", 64'(o_busy), 64'h1);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_busy",  64'(o_busy),  64'h0);
    check("flush_ready", 64'(o_ready), 64'h1);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'h0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    i_valid = 1'b1; i_flush = 1'b1; i_op = DIVU; i_rs1 = 64'd5; i_rs2 = 64'd0;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("idle_flush_block", 64'(o_busy), 64'h0);

    // DONE holds result/rd stable while i_ready is low
    @(negedge clk);
    i_valid = 1'b1; i_op = MUL; i_is_word = 1'b0; i_rs1 = 64'd7; i_rs2 = 64'd3; i_rd = 5'd21;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_result", o_result, 64'd21);
    r0 = o_result; rd0 = o_rd; bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!o_valid || o_result !== r0 || o_rd !== rd0) bad++;
    end
    check("hold_stable", 64'(bad), 64'h0);
    check("hold_rd", 64'(o_rd), 64'd21);
    check("done_ready_low", 64'(o_ready), 64'h0);

    // i_ready with a new request in DONE: not accepted on that edge
    i_ready = 1'b1; i_valid = 1'b1; i_op = DIVU; i_rs1 = 64'd9; i_rs2 = 64'd0; i_rd = 5'd4;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("done_no_accept_busy",  64'(o_busy),  64'h0);
    check("done_no_accept_ready", 64'(o_ready), 64'h1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("next_accept_valid",  64'(o_valid), 64'h1);
    check("next_accept_result", o_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("next_accept_rd",     64'(o_rd), 64'd4);

    // Flush (with i_ready) in DONE drops the result
    i_flush = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_ready = 1'b0;
    check("done_flush_valid", 64'(o_valid), 64'h0);
    check("done_flush_ready", 64'(o_ready), 64'h1);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    i_valid = 1'b1; i_op = MULHU; i_is_word = 1'b0; i_rs1 = 64'hFFFF; i_rs2 = 64'hFFFF; i_rd = 5'd17;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",   64'(o_busy),  64'h0);
    check("arst_valid",  64'(o_valid), 64'h0);
    check("arst_ready",  64'(o_ready), 64'h1);
    check("arst_result", o_result,     64'h0);
    check("arst_rd",     64'(o_rd),    64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("arst_no_valid", 64'(seen), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 64: operand/result width; SHALL be 32 or 64.
REQ-002 Parameter UNROLL, default 1: bits processed per iteration; SHALL be 1, 2 or 4.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 i_valid  input  1  request valid.
REQ-007 o_ready  output  1  unit can accept a request.
REQ-008 i_op  input  3  operation, RV M-extension funct3 encoding.
REQ-009 i_is_word  input  1  W-variant: 32-bit operation, result sign-extended; ignored when XLEN=32.
REQ-010 i_rs1, i_rs2  input  XLEN  operands.
REQ-011 i_rd  input  5  destination tag.
REQ-012 i_flush  input  1  kill in-flight or pending operation.
REQ-013 o_valid  output  1  result valid.
REQ-014 i_ready  input  1  consumer accepts result.
REQ-015 o_result  output  XLEN  result.
REQ-016 o_rd  output  5  destination tag of the result, for the hazard/stall controller.
REQ-017 o_busy  output  1  state is not IDLE.

Function
REQ-018 FSM states: IDLE, BUSY, DONE; o_ready SHALL be 1 only in IDLE.
REQ-019 Accept on i_valid && o_ready && !i_flush: latch operands, op, word flag and rd; enter BUSY (normal case) or DONE (special case).
REQ-020 Iteration count N = W/UNROLL, where W = 32 for word ops, else XLEN; BUSY lasts exactly N cycles, then DONE.
REQ-021 Latency: o_valid SHALL rise N+1 clock edges after the accept edge; special cases after 1 edge.
REQ-022 Multiply: shift-add on operand magnitudes; the 2W-bit product is sign-corrected for MUL/MULH (s*s) and MULHSU (s*u). MUL returns the low W bits; MULH/MULHSU/MULHU return the high W bits.
REQ-023 Divide: restoring division on magnitudes; quotient negated if operand signs differ (signed ops); remainder takes the dividend's sign.
REQ-024 Divide by zero (special): quotient = all ones, remainder = dividend (W-bit).
REQ-025 Signed overflow, most-negative / -1 (special): quotient = dividend, remainder = 0.
REQ-026 Word ops: inputs use bits [31:0]; the result is bit 31 sign-extended to XLEN.
REQ-027 DONE: o_valid=1, o_result and o_rd stable until i_valid... i.e. until i_ready; on i_ready go to IDLE.
REQ-028 DONE with i_ready asserted: the next request SHALL NOT be accepted in the same cycle (o_ready=0 in DONE).
REQ-029 i_flush in BUSY or DONE: return to IDLE next edge, no o_valid for that operation; i_flush in IDLE blocks acceptance that cycle.
REQ-030 i_flush has priority over i_ready in DONE.

Reset
REQ-031 rst SHALL force IDLE asynchronously, at any state including mid-iteration.
REQ-032 Reset values: o_valid=0, o_ready=1 (combinational from IDLE), o_busy=0, o_result=0, o_rd=0, iteration counter=0, accumulators=0.
REQ-033 No result from an operation interrupted by reset SHALL ever appear.

Structure
REQ-034 The shared package (struct_pckg) SHALL hold the muldiv_op_e enum (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7) and the FSM state typedef.
REQ-035 Counter width SHALL be $clog2(XLEN/UNROLL+1); the parameter check SHALL be an elaboration-time assertion.
REQ-036 One sub-module, ex_muldiv_step: combinational single-iteration datapath (UNROLL add or subtract steps), instantiated once.

Verification (XLEN=64, UNROLL=1)
REQ-037 MUL 7 * 0xFFFF_FFFF_FFFF_FFFD -> 0xFFFF_FFFF_FFFF_FFEB; o_valid exactly 65 edges after accept.
REQ-038 MULHU 0xFFFF_FFFF_FFFF_FFFF * 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-039 DIVU 100/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 100/0 -> 100; both 1 edge after accept.
REQ-040 DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM -> 0; 1 edge.
REQ-041 DIVW 0x0000_0000_FFFF_FFF6 / 3 -> 0xFFFF_FFFF_FFFF_FFFD after 33 edges; REMW -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-042 i_flush 10 cycles into BUSY -> IDLE next edge, no o_valid; i_ready held low 20 cycles in DONE -> o_result/o_rd stable; rst mid-BUSY -> all REQ-032 values, no spurious o_valid.
